// File: rtl/sgbm_pixel_scheduler_if.sv
// Memory-read and census-issue bus of the SGBM pixel scheduler.
// master = scheduler side, slave = image RAMs / census units / result feedback.
interface sgbm_pixel_scheduler_if #(
  parameter int ADDR_W = 17
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_left_data;
  logic [7:0]        mem_right_data;
  logic              en;
  logic [7:0]        grey_left;
  logic [7:0]        grey_right;
  logic [9:0]        row_out;
  logic [9:0]        col_out;
  logic              res_valid;

  modport master (
    output mem_rd, mem_addr, en, grey_left, grey_right, row_out, col_out,
    input  mem_left_data, mem_right_data, res_valid
  );

  modport slave (
    input  mem_rd, mem_addr, en, grey_left, grey_right, row_out, col_out,
    output mem_left_data, mem_right_data, res_valid
  );
endinterface

// File: rtl/sgbm_pixel_scheduler.sv
// Raster-order pixel issuer for the SGBM pipeline with drain detection and frame restart.
// Optional drain watchdog enabled by defining SGBM_SCHED_TIMEOUT_EN.
module sgbm_pixel_scheduler #(
  parameter int IMG_ROW       = 200,
  parameter int IMG_COL       = 400,
  parameter int PIX_INTERVAL  = 13,
  parameter int ADDR_W        = 17,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  sgbm_pixel_scheduler_if.master bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [4:0]            frame_cnt,
  output logic                  timeout,
  output logic [2:0]            state_dbg
);

  // Handshake: mem_rd strobes one read; data is expected one cycle later, when en pulses with
  // grey/row/col. en has no back-pressure; res_valid is a one-cycle count pulse per finished pixel.

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int                TOTAL     = IMG_ROW * IMG_COL;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W:0]   TOTAL_CNT = (ADDR_W + 1)'(TOTAL);
  localparam logic [9:0]        COL_LAST  = 10'(IMG_COL - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(PIX_INTERVAL - 2);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [ADDR_W-1:0] pix_idx;
  logic [9:0]        row;
  logic [9:0]        col;
  logic [7:0]        gap_cnt;
  logic [ADDR_W:0]   vcnt;
  logic              en_q;
  logic [7:0]        left_hold;
  logic [7:0]        right_hold;
  logic [9:0]        row_q;
  logic [9:0]        col_q;
  logic              last_pix;
  logic              frame_start;
  logic              drain_full;
  logic              count_window;
  logic              drain_expire;

  assign last_pix     = (pix_idx == LAST_IDX);
  assign frame_start  = ((state == S_IDLE) && start) || ((state == S_DONE) && continuous);
  assign drain_full   = (vcnt == TOTAL_CNT);
  assign count_window = (state == S_ISSUE) || (state == S_GAP) || (state == S_DRAIN);

`ifdef SGBM_SCHED_TIMEOUT_EN
  localparam int DT_W = $clog2(DRAIN_TIMEOUT + 1);

  logic [DT_W-1:0] drain_cnt;

  assign drain_expire = (state == S_DRAIN) && !drain_full &&
                        (drain_cnt == DT_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      drain_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DT_W'(1) : '0;
      // Sticky until the next user start; a continuous restart keeps it visible.
      if ((state == S_IDLE) && start) begin
        timeout <= 1'b0;
      end else if (drain_expire) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  assign drain_expire = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (last_pix) begin
          state_nx = S_DRAIN;
        end else if (PIX_INTERVAL > 1) begin
          state_nx = S_GAP;
        end else begin
          state_nx = S_ISSUE;
        end
      end
      S_GAP:   if (gap_cnt == GAP_LAST) state_nx = S_ISSUE;
      S_DRAIN: if (drain_full || drain_expire) state_nx = S_DONE;
      S_DONE:  state_nx = continuous ? S_ISSUE : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      pix_idx   <= '0;
      row       <= '0;
      col       <= '0;
      gap_cnt   <= '0;
      vcnt      <= '0;
      frame_cnt <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (frame_start) begin
        pix_idx <= '0;
        row     <= '0;
        col     <= '0;
        vcnt    <= '0;
      end else begin
        if (state == S_ISSUE) begin
          if (last_pix) begin
            pix_idx <= '0;
            row     <= '0;
            col     <= '0;
          end else begin
            pix_idx <= pix_idx + ADDR_W'(1);
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 10'd1;
            end else begin
              col <= col + 10'd1;
            end
          end
        end
        if (count_window && bus.res_valid && !drain_full) begin
          vcnt <= vcnt + (ADDR_W + 1)'(1);
        end
      end
      if (state_nx == S_DONE) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  // Output stage: tags follow the read by one cycle so they line up with the RAM data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      left_hold  <= '0;
      right_hold <= '0;
    end else begin
      en_q <= (state == S_ISSUE);
      if (state == S_ISSUE) begin
        row_q <= row;
        col_q <= col;
      end else if (state_nx == S_DONE) begin
        row_q <= '0;
        col_q <= '0;
      end
      if (state_nx == S_DONE) begin
        left_hold  <= '0;
        right_hold <= '0;
      end else if (en_q) begin
        left_hold  <= bus.mem_left_data;
        right_hold <= bus.mem_right_data;
      end
    end
  end

  assign bus.mem_rd     = (state == S_ISSUE);
  assign bus.mem_addr   = pix_idx;
  assign bus.en         = en_q;
  assign bus.grey_left  = en_q ? bus.mem_left_data  : left_hold;
  assign bus.grey_right = en_q ? bus.mem_right_data : right_hold;
  assign bus.row_out    = row_q;
  assign bus.col_out    = col_q;

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_sgbm_pixel_scheduler.sv
// Scoreboard bench for sgbm_pixel_scheduler: 4x5 image, interval 3 (dut_a) and interval 1 (dut_b).
module tb_sgbm_pixel_scheduler;
  localparam int ROWS = 4;
  localparam int COLS = 5;
  localparam int PI_A = 3;
  localparam int AW   = 5;
  localparam int DT   = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, cont_a = 1'b0, start_b = 1'b0, cont_b = 1'b0;
  logic busy_a, done_a, to_a, busy_b, done_b, to_b;
  logic [4:0] fcnt_a, fcnt_b;
  logic [2:0] st_a, st_b;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic withhold_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sgbm_pixel_scheduler_if #(.ADDR_W(AW)) bus_a ();
  sgbm_pixel_scheduler_if #(.ADDR_W(AW)) bus_b ();

  sgbm_pixel_scheduler #(.IMG_ROW(ROWS), .IMG_COL(COLS), .PIX_INTERVAL(PI_A), .ADDR_W(AW),
                         .DRAIN_TIMEOUT(DT)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .continuous(cont_a), .bus(bus_a),
    .busy(busy_a), .frame_done(done_a), .frame_cnt(fcnt_a), .timeout(to_a), .state_dbg(st_a)
  );

  sgbm_pixel_scheduler #(.IMG_ROW(ROWS), .IMG_COL(COLS), .PIX_INTERVAL(1), .ADDR_W(AW),
                         .DRAIN_TIMEOUT(DT)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .continuous(cont_b), .bus(bus_b),
    .busy(busy_b), .frame_done(done_b), .frame_cnt(fcnt_b), .timeout(to_b), .state_dbg(st_b)
  );

  // Image contents: left = 7a+3, right = 200-5a (mod 256).
  function automatic logic [7:0] pix_left(input int a);
    return 8'(a * 7 + 3);
  endfunction
  function automatic logic [7:0] pix_right(input int a);
    return 8'(200 - a * 5);
  endfunction

  // RAM models (1-cycle read) and result echo 8 cycles after en.
  logic [7:0] sr_a, sr_b;
  always @(posedge clk) begin
    if (!rst) begin
      bus_a.mem_left_data <= '0; bus_a.mem_right_data <= '0;
      bus_b.mem_left_data <= '0; bus_b.mem_right_data <= '0;
      sr_a <= '0; sr_b <= '0;
    end else begin
      if (bus_a.mem_rd) begin
        bus_a.mem_left_data  <= pix_left(int'(bus_a.mem_addr));
        bus_a.mem_right_data <= pix_right(int'(bus_a.mem_addr));
      end
      if (bus_b.mem_rd) begin
        bus_b.mem_left_data  <= pix_left(int'(bus_b.mem_addr));
        bus_b.mem_right_data <= pix_right(int'(bus_b.mem_addr));
      end
      sr_a <= {sr_a[6:0], bus_a.en &&
               !(withhold_on && bus_a.row_out == 10'd1 && bus_a.col_out == 10'd0)};
      sr_b <= {sr_b[6:0], bus_b.en};
    end
  end
  assign bus_a.res_valid = sr_a[7];
  assign bus_b.res_valid = sr_b[7];

  logic [35:0]   exp_q_a[$];
  logic [AW-1:0] addr_q_a[$];
  logic [5:0]    done_q_a[$];
  logic [35:0]   exp_q_b[$];
  logic [AW-1:0] addr_q_b[$];
  logic [5:0]    done_q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] exp_pix(input int r, input int c);
    int a;
    a = r * COLS + c;
    return {10'(r), 10'(c), pix_left(a), pix_right(a)};
  endfunction

  task automatic push_frame(input int which);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (which == 0) begin
          exp_q_a.push_back(exp_pix(r, c));
          addr_q_a.push_back(AW'(r * COLS + c));
        end else begin
          exp_q_b.push_back(exp_pix(r, c));
          addr_q_b.push_back(AW'(r * COLS + c));
        end
      end
    end
  endtask

  // Monitor for dut_a: read addresses and spacing, issued pixels, frame completions.
  int last_rd_a = 0;
  always @(negedge clk) begin
    if (bus_a.mem_rd) begin
      if (addr_q_a.size() == 0) check("a_rd_unexpected", 1, 0);
      else check("a_rd_addr", 64'(bus_a.mem_addr), 64'(addr_q_a.pop_front()));
      if (bus_a.mem_addr != '0) check("a_rd_spacing", 64'(cyc - last_rd_a), 64'(PI_A));
      last_rd_a = cyc;
    end
    if (bus_a.en) begin
      if (exp_q_a.size() == 0) check("a_en_unexpected", 1, 0);
      else check("a_pixel", 64'({bus_a.row_out, bus_a.col_out, bus_a.grey_left, bus_a.grey_right}),
                 64'(exp_q_a.pop_front()));
    end
    if (done_a) begin
      if (done_q_a.size() == 0) check("a_done_unexpected", 1, 0);
      else check("a_done_to_cnt", 64'({to_a, fcnt_a}), 64'(done_q_a.pop_front()));
    end
  end

  // Monitor for dut_b: reads and en pulses must be back-to-back within a frame.
  int last_rd_b = 0;
  logic prev_en_b = 1'b0;
  always @(negedge clk) begin
    if (bus_b.mem_rd) begin
      if (addr_q_b.size() == 0) check("b_rd_unexpected", 1, 0);
      else check("b_rd_addr", 64'(bus_b.mem_addr), 64'(addr_q_b.pop_front()));
      if (bus_b.mem_addr != '0) check("b_rd_spacing", 64'(cyc - last_rd_b), 64'd1);
      last_rd_b = cyc;
    end
    if (bus_b.en) begin
      if (bus_b.row_out != '0 || bus_b.col_out != '0) check("b_back_to_back", 64'(prev_en_b), 64'd1);
      if (exp_q_b.size() == 0) check("b_en_unexpected", 1, 0);
      else check("b_pixel", 64'({bus_b.row_out, bus_b.col_out, bus_b.grey_left, bus_b.grey_right}),
                 64'(exp_q_b.pop_front()));
    end
    if (done_b) begin
      if (done_q_b.size() == 0) check("b_done_unexpected", 1, 0);
      else check("b_done_to_cnt", 64'({to_b, fcnt_b}), 64'(done_q_b.pop_front()));
    end
    prev_en_b = bus_b.en;
  end

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, input string name);
    int seen;
    seen = 0;
    for (int n = 0; n < limit && seen == 0; n++) begin
      @(negedge clk);
      if ((which == 0) ? done_a : done_b) seen = 1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic flush_a();
    exp_q_a.delete();
    addr_q_a.delete();
    done_q_a.delete();
  endtask

  initial begin
    // Reset held with start asserted: everything quiet.
    rst = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t1_reset_outs", 64'({bus_a.mem_rd, bus_a.en, busy_a, done_a, fcnt_a, to_a,
            bus_a.grey_left, bus_a.grey_right, bus_a.row_out, bus_a.col_out, bus_a.mem_addr}), 64'd0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t1_after_release", 64'({bus_a.en, busy_a, bus_a.mem_rd, bus_b.en, busy_b}), 64'd0);

    // Single frame, interval 3.
    push_frame(0);
    done_q_a.push_back({1'b0, 5'd1});
    pulse_start(0);
    wait_done(0, 400, "t2_done_seen");
    @(negedge clk);
    check("t2_busy_drop", 64'(busy_a), 64'd0);
    check("t2_frame_cnt", 64'(fcnt_a), 64'd1);
    check("t2_outs_cleared", 64'({bus_a.grey_left, bus_a.grey_right, bus_a.row_out, bus_a.col_out}), 64'd0);
    check("t2_queue_empty", 64'(exp_q_a.size()), 64'd0);

    // Interval 1 on the second instance.
    push_frame(1);
    done_q_b.push_back({1'b0, 5'd1});
    pulse_start(1);
    wait_done(1, 200, "t3_done_seen");
    @(negedge clk);
    check("t3_frame_cnt", 64'(fcnt_b), 64'd1);
    check("t3_queue_empty", 64'(exp_q_b.size() + addr_q_b.size()), 64'd0);

    // Three continuous frames; continuous dropped during the third.
    cont_a = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_frame(0);
      done_q_a.push_back({1'b0, 5'(2 + f)});
    end
    pulse_start(0);
    for (int f = 0; f < 3; f++) begin
      wait_done(0, 400, "t4_done_seen");
      @(negedge clk);
      if (f < 2) begin
        check("t4_restart_rd", 64'({bus_a.mem_rd, bus_a.mem_addr}), 64'({1'b1, AW'(0)}));
        if (f == 1) cont_a = 1'b0;
      end else begin
        check("t4_busy_drop", 64'(busy_a), 64'd0);
      end
    end
    check("t4_frame_cnt", 64'(fcnt_a), 64'd4);

    // Reset at pixel 7, then a clean restart.
    push_frame(0);
    pulse_start(0);
    for (int n = 0; n < 400 && exp_q_a.size() > 13; n++) @(negedge clk);
    check("t5_reached_pixel7", 64'(exp_q_a.size()), 64'd13);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_reset_outs", 64'({bus_a.mem_rd, bus_a.en, busy_a, fcnt_a, bus_a.grey_left,
          bus_a.row_out, bus_a.col_out}), 64'd0);
    flush_a();
    rst = 1'b1;
    @(negedge clk);
    check("t5_no_en_after_reset", 64'({bus_a.en, busy_a}), 64'd0);
    push_frame(0);
    done_q_a.push_back({1'b0, 5'd1});
    pulse_start(0);
    wait_done(0, 400, "t5_done_seen");
    @(negedge clk);
    check("t5_frame_cnt", 64'(fcnt_a), 64'd1);

    // One result withheld: watchdog forces completion, or the frame stays in drain.
    withhold_on = 1'b1;
    push_frame(0);
`ifdef SGBM_SCHED_TIMEOUT_EN
    done_q_a.push_back({1'b1, 5'd2});
    pulse_start(0);
    wait_done(0, 400, "t6_timeout_done");
    @(negedge clk);
    check("t6_timeout_sticky", 64'({to_a, busy_a}), 64'({1'b1, 1'b0}));
    withhold_on = 1'b0;
    push_frame(0);
    done_q_a.push_back({1'b0, 5'd3});
    pulse_start(0);
    check("t6_timeout_cleared", 64'(to_a), 64'd0);
    wait_done(0, 400, "t6_next_done");
`else
    pulse_start(0);
    repeat (150) @(negedge clk);
    check("t6_stuck_in_drain", 64'({busy_a, st_a, to_a}), 64'({1'b1, 3'd3, 1'b0}));
    check("t6_queue_empty", 64'(exp_q_a.size()), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    withhold_on = 1'b0;
    flush_a();
    rst = 1'b1;
    @(negedge clk);
    check("t6_recovered_idle", 64'({busy_a, fcnt_a}), 64'd0);
`endif
    check("final_done_q_empty", 64'(done_q_a.size() + done_q_b.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    total++;
    bad++;
    $display("FAIL global_time_limit actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
